// File: rtl/fir_decimator.sv
// Keeps 1 of every DECIMATION valid filter samples, saturates each kept sample to OUT_WIDTH
// and queues it in a small FIFO that drains through a valid/ready port.
module fir_decimator #(
  parameter int IN_WIDTH   = 17,
  parameter int OUT_WIDTH  = 16,
  parameter int DECIMATION = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic signed [IN_WIDTH-1:0]          in_data,
  input  logic                                in_valid,
  input  logic                                resync,
  output logic signed [OUT_WIDTH-1:0]         out_data,
  output logic                                out_clipped,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
  output logic                                overflow,
  output logic [CNT_WIDTH-1:0]                drop_count,
  input  logic                                clear_overflow
);

  localparam int PH_W = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(DECIMATION - 1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);

  logic [PH_W-1:0]          phase, phase_base, phase_next;
  logic                     keep;
  logic [IN_WIDTH-OUT_WIDTH:0] upper;
  logic                     sat_clip;
  logic [OUT_WIDTH-1:0]     sat_data;
  logic                     stg_valid, stg_clip;
  logic [OUT_WIDTH-1:0]     stg_data;
  logic [OUT_WIDTH:0]       mem [FIFO_DEPTH];
  logic [OUT_WIDTH:0]       head;
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic                     full, pop, wr, drop;

  // resync restarts the phase before the current sample is considered
  always_comb begin
    phase_base = resync ? '0 : phase;
    phase_next = phase_base;
    if (in_valid)
      phase_next = (phase_base == PH_LAST) ? '0 : phase_base + 1'b1;
  end

  assign keep = in_valid && (resync || (phase == '0));

  // The sample fits iff every bit from the sign down to bit OUT_WIDTH-1 agrees
  always_comb begin
    upper    = in_data[IN_WIDTH-1:OUT_WIDTH-1];
    sat_clip = !((&upper) || !(|upper));
    sat_data = in_data[OUT_WIDTH-1:0];
    if (sat_clip)
      sat_data = in_data[IN_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                     : {1'b0, {(OUT_WIDTH-1){1'b1}}};
  end

  assign full      = (fifo_count == FULL_CNT);
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign wr        = stg_valid && (!full || pop);
  assign drop      = stg_valid && full && !pop;

  assign head        = mem[rd_ptr];
  assign out_data    = out_valid ? head[OUT_WIDTH-1:0] : '0;
  assign out_clipped = out_valid && head[OUT_WIDTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      phase     <= '0;
      stg_valid <= 1'b0;
      stg_clip  <= 1'b0;
      stg_data  <= '0;
    end else begin
      phase     <= phase_next;
      stg_valid <= keep;
      if (keep) begin
        stg_clip <= sat_clip;
        stg_data <= sat_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr)
      mem[wr_ptr] <= {stg_clip, stg_data};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // A clear in the same cycle as a drop takes priority
  always_ff @(posedge clock) begin
    if (reset || clear_overflow) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1)
        drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_decimator.sv
// Directed bench for fir_decimator with hand-computed expectations (DECIMATION=4, depth 8).
module tb_fir_decimator;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic signed [16:0] in_data = '0;
  logic               in_valid = 1'b0;
  logic               resync = 1'b0;
  logic signed [15:0] out_data;
  logic               out_clipped;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [3:0]         fifo_count;
  logic               overflow;
  logic [15:0]        drop_count;
  logic               clear_overflow = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  fir_decimator #(
    .IN_WIDTH(17), .OUT_WIDTH(16), .DECIMATION(4), .FIFO_DEPTH(8), .CNT_WIDTH(16)
  ) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .resync(resync), .out_data(out_data), .out_clipped(out_clipped),
    .out_valid(out_valid), .out_ready(out_ready), .fifo_count(fifo_count),
    .overflow(overflow), .drop_count(drop_count), .clear_overflow(clear_overflow)
  );

  always #5 clock = ~clock;

  // Inputs change 1 time unit after an edge; outputs are sampled at the same point
  task automatic applyStimulus(input logic v, input int d, input logic rs);
    in_valid = v;
    in_data  = 17'(d);
    resync   = rs;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic keepAndCheck(input int d, input int exp_data, input int exp_clip);
    applyStimulus(1'b1, d, 1'b0);
    applyStimulus(1'b1, 0, 1'b0);
    checkOutput("sat_valid", int'(out_valid), 1);
    checkOutput("sat_data", int'(out_data), exp_data);
    checkOutput("sat_clip", int'(out_clipped), exp_clip);
    applyStimulus(1'b1, 0, 1'b0);
    applyStimulus(1'b1, 0, 1'b0);
  endtask

  initial begin
    applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("rst_valid", int'(out_valid), 0);
    checkOutput("rst_count", int'(fifo_count), 0);
    checkOutput("rst_data", int'(out_data), 0);
    checkOutput("rst_clip", int'(out_clipped), 0);
    checkOutput("rst_ovf", int'(overflow), 0);
    checkOutput("rst_drops", int'(drop_count), 0);
    reset = 1'b0;

    $display("[TB] decimation by 4 of a ramp");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, i, 1'b0);
      checkOutput($sformatf("ramp_valid_%0d", i), int'(out_valid), (i % 4 == 1) ? 1 : 0);
      if (i % 4 == 1)
        checkOutput($sformatf("ramp_data_%0d", i), int'(out_data), i - 1);
    end
    applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);

    $display("[TB] saturation");
    keepAndCheck(40000, 32767, 1);
    keepAndCheck(-40000, -32768, 1);
    keepAndCheck(-5, -5, 0);
    keepAndCheck(32767, 32767, 0);
    keepAndCheck(32768, 32767, 1);
    keepAndCheck(-32768, -32768, 0);
    keepAndCheck(-32769, -32768, 1);
    applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("sat_drained", int'(out_valid), 0);

    $display("[TB] overflow with consumer stalled");
    out_ready = 1'b0;
    for (int j = 0; j < 48; j++)
      applyStimulus(1'b1, 100 + j, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("ovf_count", int'(fifo_count), 8);
    checkOutput("ovf_flag", int'(overflow), 1);
    checkOutput("ovf_drops", int'(drop_count), 4);
    checkOutput("ovf_head", int'(out_data), 100);
    applyStimulus(1'b1, 500, 1'b0);
    checkOutput("stall_head", int'(out_data), 100);

    $display("[TB] full FIFO with simultaneous pop");
    out_ready = 1'b1;
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("full_pop_count", int'(fifo_count), 8);
    checkOutput("full_pop_drops", int'(drop_count), 4);
    for (int k = 1; k < 8; k++) begin
      checkOutput($sformatf("drain_%0d", k), int'(out_data), 100 + 4 * k);
      applyStimulus(1'b0, 0, 1'b0);
    end
    checkOutput("drain_last", int'(out_data), 500);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("drain_empty", int'(out_valid), 0);
    checkOutput("drain_count", int'(fifo_count), 0);
    clear_overflow = 1'b1;
    applyStimulus(1'b0, 0, 1'b0);
    clear_overflow = 1'b0;
    checkOutput("clr_flag", int'(overflow), 0);
    checkOutput("clr_drops", int'(drop_count), 0);

    $display("[TB] resync");
    applyStimulus(1'b1, 1, 1'b0);
    applyStimulus(1'b1, 777, 1'b1);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("rs_valid", int'(out_valid), 1);
    checkOutput("rs_data", int'(out_data), 777);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("rs_pop", int'(out_valid), 0);
    applyStimulus(1'b1, 11, 1'b0);
    applyStimulus(1'b1, 12, 1'b0);
    checkOutput("rs_skip1", int'(out_valid), 0);
    applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b1, 13, 1'b0);
    applyStimulus(1'b1, 14, 1'b0);
    checkOutput("rs_skip2", int'(out_valid), 0);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("rs_next_valid", int'(out_valid), 1);
    checkOutput("rs_next_data", int'(out_data), 14);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("rs_next_pop", int'(out_valid), 0);

    $display("[TB] reset mid-stream");
    out_ready = 1'b0;
    for (int j = 0; j < 20; j++)
      applyStimulus(1'b1, 200 + j, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("pre_rst_count", int'(fifo_count), 5);
    checkOutput("pre_rst_head", int'(out_data), 203);
    reset = 1'b1;
    applyStimulus(1'b1, 9, 1'b0);
    checkOutput("mid_rst_valid", int'(out_valid), 0);
    checkOutput("mid_rst_count", int'(fifo_count), 0);
    checkOutput("mid_rst_ovf", int'(overflow), 0);
    checkOutput("mid_rst_data", int'(out_data), 0);
    reset = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b1, 321, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("post_rst_valid", int'(out_valid), 1);
    checkOutput("post_rst_data", int'(out_data), 321);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
